// File: rtl/tcrc_pkg.sv
// Shared types, constants and helpers for the tcrc32 FCS append stage.
package tcrc_pkg;
  localparam int unsigned LANES     = 32;
  localparam int unsigned TW        = 5;
  localparam int unsigned FCS_BYTES = 4;

  typedef logic [7:0] byte_lane_t;

  typedef enum logic {PASS, SPILL} fcs_state_t;

  // Valid-byte count from tag; a zero tag means a full 32-byte beat.
  function automatic logic [5:0] tag2len(input logic [TW-1:0] tag);
    return (tag == '0) ? 6'd32 : {1'b0, tag};
  endfunction

  // FCS bytes go out least-significant CRC byte first.
  function automatic byte_lane_t fcs_byte(input logic [31:0] crc, input logic [1:0] idx);
    case (idx)
      2'd0:    return crc[7:0];
      2'd1:    return crc[15:8];
      2'd2:    return crc[23:16];
      default: return crc[31:24];
    endcase
  endfunction
endpackage

// File: rtl/fcs_lane_mux.sv
// Merges the 4 FCS bytes into an eop beat behind its last valid byte and
// produces the overflow bytes for the spill beat. Purely combinational.
module fcs_lane_mux
  import tcrc_pkg::*;
(
  input  logic [255:0] data,
  input  logic [5:0]   n,
  input  logic [31:0]  crc,
  output logic [255:0] merged,
  output logic [31:0]  spill_word,
  output logic [2:0]   spill_cnt
);

  int unsigned len;

  // Lane 0 sits at the top of the beat; lanes past the FCS are forced to 0.
  always_comb begin
    merged     = '0;
    spill_word = '0;
    spill_cnt  = '0;
    len        = 32'(n);
    for (int unsigned l = 0; l < LANES; l++) begin
      if (l < len)
        merged[8*(LANES-1-l) +: 8] = data[8*(LANES-1-l) +: 8];
      else if (l < len + FCS_BYTES)
        merged[8*(LANES-1-l) +: 8] = fcs_byte(crc, 2'(l - len));
    end
    if (len > LANES - FCS_BYTES) begin
      spill_cnt = 3'(len - (LANES - FCS_BYTES));
      for (int unsigned j = 0; j < FCS_BYTES; j++) begin
        if (j < 32'(spill_cnt))
          spill_word[8*(FCS_BYTES-1-j) +: 8] = fcs_byte(crc, 2'(LANES - len + j));
      end
    end
  end

endmodule

// File: rtl/tcrc32_fcs_append.sv
// Appends the 4-byte FCS after the last valid byte of each frame, emitting a
// single spill beat when the FCS does not fit in the eop beat.
module tcrc32_fcs_append #(
  parameter int DW         = 256,
  parameter int TW         = 5,
  parameter int CRC_INVERT = 0
) (
  input  logic          i_clk,
  input  logic          i_areset_n,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data256,
  input  logic [TW-1:0] i_tag,
  input  logic          i_sop,
  input  logic          i_eop,
  input  logic          i_crc_valid,
  input  logic [31:0]   i_crc,
  output logic          o_valid,
  output logic [DW-1:0] o_data256,
  output logic [TW-1:0] o_tag,
  output logic          o_sop,
  output logic          o_eop,
  output logic          o_err_overrun,
  output logic          o_err_proto
);
  import tcrc_pkg::*;

  fcs_state_t  state;
  logic        frame_open;
  logic [31:0] spill_word_q;
  logic [2:0]  spill_cnt_q;

  logic [5:0]    len;
  logic          fits;
  logic [31:0]   crc_eff;
  logic [DW-1:0] merged;
  logic [31:0]   spill_word;
  logic [2:0]    spill_cnt;

  // CRC actually appended: zero when unqualified, optionally inverted.
  always_comb begin
    len  = tag2len(i_tag);
    fits = (len <= 6'(LANES - FCS_BYTES));
    if (!i_crc_valid)
      crc_eff = '0;
    else if (CRC_INVERT != 0)
      crc_eff = ~i_crc;
    else
      crc_eff = i_crc;
  end

  fcs_lane_mux u_mux (
    .data       (i_data256),
    .n          (len),
    .crc        (crc_eff),
    .merged     (merged),
    .spill_word (spill_word),
    .spill_cnt  (spill_cnt)
  );

  // Output register, PASS/SPILL state, frame tracking and sticky error flags.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state         <= PASS;
      frame_open    <= 1'b0;
      spill_word_q  <= '0;
      spill_cnt_q   <= '0;
      o_valid       <= 1'b0;
      o_data256     <= '0;
      o_tag         <= '0;
      o_sop         <= 1'b0;
      o_eop         <= 1'b0;
      o_err_overrun <= 1'b0;
      o_err_proto   <= 1'b0;
    end else begin
      o_valid   <= 1'b0;
      o_data256 <= '0;
      o_tag     <= '0;
      o_sop     <= 1'b0;
      o_eop     <= 1'b0;
      case (state)
        SPILL: begin
          // Input beats in this slot are dropped and do not touch frame tracking.
          o_valid      <= 1'b1;
          o_data256    <= {spill_word_q, {(DW-32){1'b0}}};
          o_tag        <= TW'(spill_cnt_q);
          o_eop        <= 1'b1;
          spill_word_q <= '0;
          spill_cnt_q  <= '0;
          state        <= PASS;
          if (i_valid)
            o_err_overrun <= 1'b1;
        end
        default: begin
          if (i_valid) begin
            if ((i_sop && frame_open) || (!i_sop && !frame_open) || (i_eop && !i_crc_valid))
              o_err_proto <= 1'b1;
            if (i_eop)
              frame_open <= 1'b0;
            else if (i_sop)
              frame_open <= 1'b1;
            o_valid <= 1'b1;
            o_sop   <= i_sop;
            if (!i_eop) begin
              o_data256 <= i_data256;
            end else begin
              o_data256 <= merged;
              if (fits) begin
                o_tag <= TW'(len + 6'(FCS_BYTES));
                o_eop <= 1'b1;
              end else begin
                spill_word_q <= spill_word;
                spill_cnt_q  <= spill_cnt;
                state        <= SPILL;
              end
            end
          end
        end
      endcase
    end
  end

endmodule
